// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: pipeline-side hazard inputs and stall/flush/redirect controls.
// master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned NSRC  = 2
);
  logic [5:0]            id_op;
  logic [5:0]            id_func;
  logic [NSRC*REG_W-1:0] id_rsel;
  logic [NSRC-1:0]       id_rvalid;
  logic                  id_equal;
  logic [REG_W-1:0]      ex_wsel;
  logic [REG_W-1:0]      mem_wsel;
  logic                  ex_wen;
  logic                  mem_wen;
  logic                  ex_dren;
  logic                  mem_dren;
  logic                  mem_dwen;
  logic                  dhit;
  logic                  ihit;
  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  stall_mem;
  logic                  flush_id;
  logic                  flush_ex;
  logic                  pc_branch;
  logic                  pc_jump;

  modport master (
    output id_op, id_func, id_rsel, id_rvalid, id_equal,
           ex_wsel, mem_wsel, ex_wen, mem_wen, ex_dren,
           mem_dren, mem_dwen, dhit, ihit,
    input  stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, pc_branch, pc_jump
  );

  modport slave (
    input  id_op, id_func, id_rsel, id_rvalid, id_equal,
           ex_wsel, mem_wsel, ex_wen, mem_wen, ex_dren,
           mem_dren, mem_dwen, dhit, ihit,
    output stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, pc_branch, pc_jump
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline, sitting beside ID.
// Optional stall-cause performance counters: define HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  hazard_ctrl_if.slave     hz,
  output logic [1:0]       hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_mem,
  output logic [CNT_W-1:0] perf_lu,
  output logic [CNT_W-1:0] perf_br,
  output logic [CNT_W-1:0] perf_flush
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_LU_STALL = 2'd2,
    ST_BR_STALL = 2'd3
  } hz_state_e;

  if (REG_W == 0 || NSRC == 0 || CNT_W == 0) begin : g_bad_param
    $error("hazard_ctrl: REG_W, NSRC and CNT_W must be non-zero");
  end

  hz_state_e hz_state_q, hz_state_d;
  logic      ex_match_c, mem_match_c;
  logic      is_beq_c, is_bne_c, is_br_c, is_jmp_c;
  logic      take_br_c, redirect_c;

  // Does any live ID source read the EX / MEM destination ($0 never matches).
  always_comb begin
    ex_match_c  = 1'b0;
    mem_match_c = 1'b0;
    for (int k = 0; k < int'(NSRC); k++) begin
      if (hz.id_rvalid[k] && (hz.id_rsel[k*REG_W +: REG_W] == hz.ex_wsel))
        ex_match_c = 1'b1;
      if (hz.id_rvalid[k] && (hz.id_rsel[k*REG_W +: REG_W] == hz.mem_wsel))
        mem_match_c = 1'b1;
    end
    if (hz.ex_wsel == '0)
      ex_match_c = 1'b0;
    if (hz.mem_wsel == '0)
      mem_match_c = 1'b0;
  end

  always_comb begin
    is_beq_c  = (hz.id_op == OP_BEQ);
    is_bne_c  = (hz.id_op == OP_BNE);
    is_br_c   = is_beq_c | is_bne_c;
    is_jmp_c  = (hz.id_op == OP_J) | (hz.id_op == OP_JAL) |
                ((hz.id_op == OP_RTYPE) & (hz.id_func == FN_JR));
    take_br_c = (is_beq_c & hz.id_equal) | (is_bne_c & ~hz.id_equal);
  end

  // Cause priority: data-memory wait, then load-use, then branch-operand.
  always_comb begin
    hz_state_d = ST_RUN;
    if ((hz.mem_dren | hz.mem_dwen) & ~hz.dhit)
      hz_state_d = ST_MEM_WAIT;
    else if (hz.ex_dren & ex_match_c)
      hz_state_d = ST_LU_STALL;
    else if (is_br_c & ((hz.ex_wen & ex_match_c) | (hz.mem_wen & mem_match_c)))
      hz_state_d = ST_BR_STALL;
  end

  // Stage controls are Mealy on the current cause; redirects only while running.
  always_comb begin
    hz.stall_if  = 1'b0;
    hz.stall_id  = 1'b0;
    hz.stall_ex  = 1'b0;
    hz.stall_mem = 1'b0;
    hz.flush_id  = 1'b0;
    hz.flush_ex  = 1'b0;
    hz.pc_branch = 1'b0;
    hz.pc_jump   = 1'b0;
    redirect_c   = 1'b0;
    unique case (hz_state_d)
      ST_MEM_WAIT: begin
        hz.stall_if  = 1'b1;
        hz.stall_id  = 1'b1;
        hz.stall_ex  = 1'b1;
        hz.stall_mem = 1'b1;
      end
      ST_LU_STALL, ST_BR_STALL: begin
        hz.stall_if = 1'b1;
        hz.stall_id = 1'b1;
        hz.flush_ex = 1'b1;
      end
      default: begin
        hz.pc_branch = take_br_c;
        hz.pc_jump   = is_jmp_c;
        redirect_c   = take_br_c | is_jmp_c;
        // Fetch miss: hold PC, let ID take a bubble so the rest drains.
        hz.stall_if  = ~hz.ihit;
        hz.flush_id  = redirect_c | ~hz.ihit;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)
      hz_state_q <= ST_RUN;
    else
      hz_state_q <= hz_state_d;
  end

  assign hz_state = hz_state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_mem_q, perf_lu_q, perf_br_q, perf_flush_q;
  logic [CNT_W-1:0] perf_mem_d, perf_lu_d, perf_br_d, perf_flush_d;

  // Saturating per-cause cycle counters.
  always_comb begin
    perf_mem_d   = perf_mem_q;
    perf_lu_d    = perf_lu_q;
    perf_br_d    = perf_br_q;
    perf_flush_d = perf_flush_q;
    if ((hz_state_d == ST_MEM_WAIT) && (perf_mem_q != '1))
      perf_mem_d = perf_mem_q + CNT_W'(1);
    if ((hz_state_d == ST_LU_STALL) && (perf_lu_q != '1))
      perf_lu_d = perf_lu_q + CNT_W'(1);
    if ((hz_state_d == ST_BR_STALL) && (perf_br_q != '1))
      perf_br_d = perf_br_q + CNT_W'(1);
    if (redirect_c && (perf_flush_q != '1))
      perf_flush_d = perf_flush_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_mem_q   <= '0;
      perf_lu_q    <= '0;
      perf_br_q    <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_mem_q   <= perf_mem_d;
      perf_lu_q    <= perf_lu_d;
      perf_br_q    <= perf_br_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_mem   = perf_mem_q;
  assign perf_lu    = perf_lu_q;
  assign perf_br    = perf_br_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and stall controller for the 5-stage MIPS pipeline. It sits beside the ID stage and detects the following hazards: load-use hazards, branch-operand dependencies, instruction-fetch misses and data-memory waits. It produces per-stage stall and flush controls plus PC redirect selects. A registered cause FSM records why the pipeline is held, and optional saturating counters track stall cycles per cause.

## Interface
Parameters
- REG_W, 5, register-address width
- NSRC, 2, source operands checked per ID instruction
- CNT_W, 16, width of each performance counter

Ports
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- id_op, id_func  in  6 each  opcode/funct of the instruction in ID
- id_rsel  in  NSRC*REG_W  source register addresses; operand k occupies bits [k*REG_W +: REG_W]
- id_rvalid  in  NSRC  operand k is actually read
- id_equal  in  1  ID register comparator: the two sources are equal
- ex_wsel / mem_wsel  in  REG_W  destination register in EX / MEM
- ex_wen / mem_wen  in  1  EX / MEM instruction writes a register
- ex_dren  in  1  EX instruction is a load
- mem_dren / mem_dwen  in  1  MEM instruction is a load / store
- dhit  in  1  data memory done this cycle
- ihit  in  1  instruction memory done this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold that stage register
- flush_id, flush_ex  out  1  load a bubble into that stage register
- pc_branch, pc_jump  out  1  PC redirect selects
- hz_state  out  2  registered cause: RUN=0, MEM_WAIT=1, LU_STALL=2, BR_STALL=3

## Operation
- Hazard terms:
  - match(w) = w!=0 and some k with id_rvalid[k] and id_rsel[k]==w.
  - is_br = id_op in {BEQ, BNE}.
  - is_jmp = id_op in {J, JAL}, or (id_op==RTYPE and id_func==JR).
- Cause, highest priority first:
  - MEM_WAIT: (mem_dren|mem_dwen) & !dhit. Asserts stall_if, stall_id, stall_ex and stall_mem. Asserts flush_id and flush_ex low.
  - LU_STALL: ex_dren & match(ex_wsel). Asserts stall_if and stall_id, and asserts flush_ex (bubble into EX).
  - BR_STALL: is_br & ((ex_wen & match(ex_wsel)) | (mem_wen & match(mem_wsel))). Asserts stall_if and stall_id, and asserts flush_ex.
  - RUN: none of the above.
- Redirect:
  - Applies only when the cause is RUN.
  - pc_branch = (BEQ & id_equal) | (BNE & !id_equal).
  - pc_jump = is_jmp.
  - Either one asserts flush_id, which squashes the fetched instruction.
  - Under any stall cause, pc_branch and pc_jump are 0.
- Fetch miss:
  - Applies when the cause is RUN and ihit==0.
  - Asserts stall_if.
  - Asserts flush_id, so ID receives a bubble and downstream stages advance.
  - A concurrent redirect still asserts its select; flush_id stays 1.
- A MEM_WAIT with an ID-side hazard present resolves MEM_WAIT first. The ID hazard is re-evaluated once dhit arrives.
- FSM: hz_state <= cause each cycle. All outputs except hz_state and the counters are combinational (Mealy) on the current inputs.
- The same-cycle load/store and dependent branch case is handled by BR_STALL on mem_wsel, because branches resolve in ID without MEM forwarding.

## Timing
- Stall, flush and redirect outputs are valid in the same cycle as their condition; zero-cycle latency.
- A load-use hazard produces exactly one bubble. In the next cycle the load is in MEM and ex_dren=0, so LU_STALL cannot re-trigger on the same load.
- A dependent branch stays in BR_STALL until no matching writer remains in EX or MEM: at most 2 cycles after the producer enters EX, longer if MEM_WAIT intervenes.
- hz_state lags the combinational cause by one cycle.
- Reset:
  - Applies in the cycle RST is high at the edge, including mid-stall.
  - hz_state=RUN and all counters=0.
  - Combinational outputs follow the inputs throughout; the pipeline's own reset clears the stage registers.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds outputs perf_mem, perf_lu, perf_br and perf_flush, each CNT_W bits.
  - Each counter increments by 1 per cycle in which its cause is active (perf_flush: flush_id from a redirect) and saturates at all-ones.
  - Counters clear on RST.
- HAZARD_PERF_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Load-use: LW $2 in EX (ex_dren=1, ex_wsel=2); ID reads $2 → one cycle of stall_if=stall_id=flush_ex=1. Next cycle all three are 0 and hz_state=LU_STALL.
- Dependent branch: BEQ in ID reads $3 with ex_wen=1, ex_wsel=3 → BR_STALL for 2 cycles with pc_branch=0. Then, with id_equal=1: pc_branch=1 and flush_id=1.
- Data miss: mem_dren=1 with dhit held low for 4 cycles → all four stall outputs=1 for 4 cycles. The cycle dhit=1 releases the stall. perf_mem=4 when HAZARD_PERF_EN is defined.
- $0 destination: ex_dren=1, ex_wsel=0, ID reads $0 → no stall.
- Jump with fetch miss: JR in ID, ihit=0 → pc_jump=1, stall_if=1, flush_id=1.
- Reset mid-MEM_WAIT: RST=1 for one cycle → hz_state=RUN and counters=0 on the next cycle.
